// File: rtl/stage_arb_pkg.sv
// Shared definitions for the staging-register arbiter and its round-robin picker.
package stage_arb_pkg;

  localparam int unsigned DEF_N_REQ = 4;
  localparam int unsigned DEF_DW    = 8;

  // Source-index width for n requesters; at least one bit.
  function automatic int unsigned sw_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_SW = sw_of(DEF_N_REQ);

  typedef logic [DEF_SW-1:0] src_idx_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/stage_reg_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request after last_grant, wrapping.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [W-1:0] grant,
  output logic         any_valid
);

  logic [W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester overrides.
  always_comb begin
    grant     = last_grant;
    any_valid = |req;
    idx       = '0;
    for (int k = N; k >= 1; k--) begin
      idx = last_grant + W'(k);
      if (req[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/stage_reg_arbiter.sv
// Round-robin arbiter feeding N_REQ byte producers into one staging register.
module stage_reg_arbiter
  import stage_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = DEF_N_REQ,
  parameter  int unsigned DW    = DEF_DW,
  localparam int unsigned SW    = sw_of(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  output logic [SW-1:0]       out_src,
  input  logic                out_ready
);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] last_q, last_d;
  logic [SW-1:0] src_q, src_d;
  logic [DW-1:0] data_q, data_d;
  logic [SW-1:0] grant;
  logic          any_valid;
  logic          load_ok;
  logic          load;
  logic [DW-1:0] req_bytes [N_REQ];

  rr_pick #(
    .N (N_REQ),
    .W (SW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_q),
    .grant      (grant),
    .any_valid  (any_valid)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) req_bytes[i] = req_data[i*DW +: DW];
  end

  // Next-state and handshake; rst_n gates req_ready so nothing is accepted in reset.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    data_d    = data_q;
    src_d     = src_q;
    req_ready = '0;
    load_ok   = rst_n && ((state_q == ST_EMPTY) || out_ready);
    load      = load_ok && any_valid;

    for (int i = 0; i < N_REQ; i++) req_ready[i] = load && (grant == SW'(i));

    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL:  if (!load && out_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (load) begin
      data_d = req_bytes[grant];
      src_d  = grant;
      last_d = grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      last_q  <= SW'(N_REQ - 1);
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: doc/stage_reg_arbiter.md
# stage_reg_arbiter

Round-robin arbiter that shares one 8-bit staging register among four independent requesters. Each requester offers a byte over a valid/ready handshake. The block grants one requester per cycle and loads that byte into the register. It then presents the byte, tagged with its source index, to a single downstream consumer over a valid/ready handshake. The block sits in front of the CDC FIFO write side, where several producers funnel into one capture register.

## Interface
Parameters:
- N_REQ, 4: number of requesters; power of two, 2..16
- DW, 8: data width
- SW, $clog2(N_REQ): source-index width (derived, not overridable)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- req_valid  input  N_REQ  bit i = requester i offers data
- req_data  input  N_REQ*DW  requester i data in bits [i*DW +: DW]
- req_ready  output  N_REQ  one-hot or zero; bit i = requester i accepted this cycle
- out_valid  output  1  staging register holds a byte
- out_data  output  DW  staged byte
- out_src  output  SW  index of the requester that supplied out_data
- out_ready  input  1  consumer takes the byte this cycle

## Operation
- Two states, tracked by out_valid:
  - EMPTY (out_valid=0)
  - FULL (out_valid=1)
- load_ok = !out_valid || out_ready.
- Arbitration is combinational:
  - Search order starts at last_grant+1 (mod N_REQ) and wraps.
  - The first i with req_valid[i]=1 wins and becomes g.
  - req_ready[g] = load_ok; all other req_ready bits are 0.
- Load (load_ok and any req_valid):
  - out_data <= req_data[g]
  - out_src <= g
  - out_valid <= 1
  - last_grant <= g
- Drain only (out_valid && out_ready, no req_valid): out_valid <= 0. out_data and out_src hold their last value.
- Simultaneous drain and load: the new byte replaces the old one and out_valid stays 1. No bubble occurs.
- FULL && !out_ready: all req_ready=0 and the register holds.
- last_grant updates only on a load. It never advances on idle cycles.
- Fairness: a continuously valid requester is granted within N_REQ loads.
- Requester rule: once req_valid[i] is high, it stays high with stable data until req_ready[i]. A violation is a protocol error; it is not detected.
- Consumer rule: out_data and out_src are stable while out_valid && !out_ready.

## Timing
- Reset values (asynchronous assert):
  - out_valid=0, out_data=0, out_src=0
  - last_grant=N_REQ-1, so requester 0 has first priority
  - req_ready=0 throughout reset
- Latency: req acceptance at edge k gives out_valid=1 with data after edge k. This is 1 cycle.
- Throughput: 1 byte/cycle while out_ready=1 and any requester is valid.
- Combinational paths:
  - req_valid -> req_ready
  - out_ready -> req_ready
  - No path from req_data to any output except through the register.
- Reset mid-operation: a staged byte is discarded. No partial handshake survives. Arbitration restarts at requester 0 after deassertion.
- Reset deassertion is synchronised externally. The block needs none internally.

## Structure
- Shared package stage_arb_pkg:
  - N_REQ and DW defaults
  - SW derivation function
  - typedef src_idx_t (logic [SW-1:0])
- One sub-module, rr_pick: a purely combinational rotate-priority picker.
  - Inputs: req vector, last_grant.
  - Outputs: grant index and any-valid flag.
  - Reused by other arbiters in the FIFO wrapper.
- Top level holds last_grant, out_valid, out_data and out_src in one always_ff with async reset.

## Test plan
- Reset, then all req_valid=0 for 5 cycles -> out_valid=0, out_data=0x00, out_src=0, req_ready=0000 every cycle.
- All four valid and held; data i = 0xA0+i; out_ready=1 -> grants in order 0,1,2,3,0. out_data sequence 0xA0,0xA1,0xA2,0xA3,0xA0, one per cycle, out_src matching.
- Requester 2 alone sends 0x5C with out_ready=0 -> out_valid=1, out_data=0x5C, out_src=2. Then requester 1 is valid with 0x33: req_ready=0000 and the byte holds for 3 cycles. Raise out_ready -> 0x33 loads on the same edge, with no idle cycle.
- Staged byte 0x77 and out_ready=1 with no requester valid -> out_valid drops next cycle and out_data stays 0x77. Then requester 3 is valid -> it is granted next, because last_grant is unchanged by idle cycles.
- Requesters 0 and 1 valid; last_grant=0 after a grant to 0 -> requester 1 is granted next, then 0. This continues, with neither starved over 8 loads.
- Assert rst_n low while FULL with out_ready=0 -> out_valid=0 immediately, without waiting for a clock edge. After release, with all four valid, the first grant is requester 0.
